pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Central sequencing/hazard controller for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB); feeds the stage enables and flushes around the execute stage.
- Generates PC/IF-ID enables, the ID/EX bubble, branch flushes and EX operand forwarding selects.
- Runs a run/step/halt debug FSM so the debug unit can single-step the core and drain it on HALT.

Parameters:
- NB_ADDRESS_REGISTROS, 5, register address width
- NB_FWD, 2, forwarding select width
- DRAIN_CYCLES, 3, cycles needed to retire in-flight instructions after HALT reaches ID
- NB_CYCLES, 32, cycle counter width

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset, asynchronous, active-high
- i_debug_mode  in  1  1 = step mode, 0 = free run
- i_step  in  1  single-cycle pulse requesting one pipeline advance (step mode only)
- i_halt_id  in  1  HALT opcode currently decoded in ID
- i_rs_id, i_rt_id  in  NB_ADDRESS_REGISTROS  source fields in IF/ID
- i_rs_ex, i_rt_ex  in  NB_ADDRESS_REGISTROS  source fields in ID/EX
- i_mem_read_ex  in  1  ID/EX instruction is a load
- i_rd_mem, i_reg_write_mem  in  NB_ADDRESS_REGISTROS, 1  EX/MEM destination and write flag
- i_rd_wb, i_reg_write_wb  in  NB_ADDRESS_REGISTROS, 1  MEM/WB destination and write flag
- i_branch_taken  in  1  branch resolved taken in MEM (branch & alu_zero)
- o_pc_en, o_if_id_en  out  1  PC and IF/ID write enables
- o_id_ex_bubble  out  1  ID/EX loads zero control
- o_if_id_flush, o_id_ex_flush, o_ex_mem_flush  out  1  stage flushes
- o_fwd_a, o_fwd_b  out  NB_FWD  EX operand select: 00 register file, 01 MEM/WB, 10 EX/MEM
- o_halted  out  1  core halted (sticky)
- o_cycle_count  out  NB_CYCLES  active-cycle counter

Behaviour:
- Reset (async): state WAIT, drain counter 0, o_cycle_count 0, o_halted 0. All enables 0 and flushes 0 while in reset.
- FSM states: WAIT, RUN, STEP, DRAIN, HALTED. State is registered; all other outputs are combinational from state and inputs.
  - WAIT: pipeline frozen (o_pc_en = o_if_id_en = 0, o_id_ex_bubble = 0, flushes 0). Goes to RUN if i_debug_mode = 0. Otherwise goes to STEP on i_step.
  - RUN: advance active. Goes to WAIT when i_debug_mode = 1.
  - STEP: advance active for exactly one cycle, then WAIT. i_step while in STEP is ignored.
  - DRAIN: PC and IF/ID frozen, o_id_ex_bubble = 1. Counts DRAIN_CYCLES cycles, then HALTED. Runs regardless of i_debug_mode.
  - HALTED: frozen as in WAIT, o_halted = 1. Leaves only on reset.
- Halt detection: in RUN or STEP, i_halt_id & ~i_branch_taken & ~stall goes to DRAIN next cycle.
  - If a stall is active, HALT stays in ID and is re-evaluated the next cycle.
  - A taken branch kills the HALT.
  - i_halt_id is ignored in DRAIN.
- Load-use stall (advance states only): stall = i_mem_read_ex & i_rt_ex != 0 & (i_rt_ex == i_rs_id | i_rt_ex == i_rt_id). Stall gives o_pc_en = 0, o_if_id_en = 0, o_id_ex_bubble = 1.
- Branch (advance states or DRAIN): i_branch_taken asserts all three flushes in the same cycle and forces o_pc_en = 1. Branch has priority over stall; stall outputs are suppressed that cycle.
- No hazard in an advance state: o_pc_en = o_if_id_en = 1, o_id_ex_bubble = 0.
- Forwarding (combinational, all states), shown for A using i_rs_ex; B is identical using i_rt_ex:
  - 10 if i_reg_write_mem & i_rd_mem != 0 & i_rd_mem == i_rs_ex.
  - Else 01 if i_reg_write_wb & i_rd_wb != 0 & i_rd_wb == i_rs_ex.
  - Else 00.
  - EX/MEM has priority over MEM/WB; register 0 is never forwarded.
- Cycle counter: increments in RUN, STEP and DRAIN (including stall cycles). Holds in WAIT and HALTED. Wraps modulo 2^NB_CYCLES.
- Reset mid-DRAIN or in HALTED returns to WAIT with the counter cleared.

Optional Feature:
- PIPE_CYCLE_COUNT_EN defined: o_cycle_count behaves as above.
- Not defined: no counter register; o_cycle_count is tied to 0.

Test Plan:
- Reset released, i_debug_mode = 0 -> cycle 1 WAIT (o_pc_en = 0); cycle 2 onward RUN, o_pc_en = 1, o_cycle_count increments 1, 2, 3.
- Step mode, i_debug_mode = 1, single i_step pulse -> o_pc_en high for exactly 1 cycle, then 0; counter +1. Two pulses spaced 5 cycles apart give exactly 2 advances.
- i_mem_read_ex = 1, i_rt_ex = 8, i_rs_id = 8 -> o_pc_en = 0, o_if_id_en = 0, o_id_ex_bubble = 1. Same with i_rt_ex = 0 -> no stall.
- Stall conditions plus i_branch_taken = 1 in the same cycle -> all flushes = 1, o_pc_en = 1, o_id_ex_bubble = 0.
- i_rd_mem = i_rd_wb = 5, both write flags = 1, i_rs_ex = 5 -> o_fwd_a = 10. Clear i_reg_write_mem -> o_fwd_a = 01. Set i_rd_mem = i_rd_wb = 0 -> o_fwd_a = 00.
- i_halt_id in RUN -> 3 DRAIN cycles (o_pc_en = 0, o_id_ex_bubble = 1), then o_halted = 1 and counter frozen. Assert i_rst during DRAIN -> WAIT, o_halted = 0, counter = 0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: sequencing and hazard controller for the 5-stage MIPS pipeline.
//
// Drives the PC and IF/ID write enables, the ID/EX bubble, the branch flushes
// and the EX operand forwarding selects. A run/step/halt debug FSM lets the
// debug unit single-step the core and drain it once a HALT reaches ID.
//
// Optional build macro:
//   PIPE_CYCLE_COUNT_EN  when defined, o_cycle_count counts active cycles
//                        (RUN, STEP, DRAIN); otherwise it is tied to zero.
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_debug_mode, i_step    1 = step mode / one-advance request pulse
//   i_halt_id               HALT opcode decoded in ID
//   i_rs_id, i_rt_id        source fields in IF/ID
//   i_rs_ex, i_rt_ex        source fields in ID/EX
//   i_mem_read_ex           ID/EX instruction is a load
//   i_rd_mem, i_reg_write_mem   EX/MEM destination and write flag
//   i_rd_wb, i_reg_write_wb     MEM/WB destination and write flag
//   i_branch_taken          branch resolved taken in MEM
//   o_pc_en, o_if_id_en     PC and IF/ID write enables
//   o_id_ex_bubble          ID/EX loads zero control
//   o_*_flush               stage flushes
//   o_fwd_a, o_fwd_b        EX operand select: 00 regfile, 01 MEM/WB, 10 EX/MEM
//   o_halted                core halted (sticky until reset)
//   o_cycle_count           active-cycle counter
module pipeline_ctrl #(
    parameter int unsigned NB_ADDRESS_REGISTROS = 5,
    parameter int unsigned NB_FWD               = 2,
    parameter int unsigned DRAIN_CYCLES         = 3,
    parameter int unsigned NB_CYCLES            = 32
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_debug_mode,
    input  logic                            i_step,
    input  logic                            i_halt_id,
    input  logic [NB_ADDRESS_REGISTROS-1:0] i_rs_id,
    input  logic [NB_ADDRESS_REGISTROS-1:0] i_rt_id,
    input  logic [NB_ADDRESS_REGISTROS-1:0] i_rs_ex,
    input  logic [NB_ADDRESS_REGISTROS-1:0] i_rt_ex,
    input  logic                            i_mem_read_ex,
    input  logic [NB_ADDRESS_REGISTROS-1:0] i_rd_mem,
    input  logic                            i_reg_write_mem,
    input  logic [NB_ADDRESS_REGISTROS-1:0] i_rd_wb,
    input  logic                            i_reg_write_wb,
    input  logic                            i_branch_taken,
    output logic                            o_pc_en,
    output logic                            o_if_id_en,
    output logic                            o_id_ex_bubble,
    output logic                            o_if_id_flush,
    output logic                            o_id_ex_flush,
    output logic                            o_ex_mem_flush,
    output logic [NB_FWD-1:0]               o_fwd_a,
    output logic [NB_FWD-1:0]               o_fwd_b,
    output logic                            o_halted,
    output logic [NB_CYCLES-1:0]            o_cycle_count
);

    localparam int unsigned DrainW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DrainW-1:0] DrainLast = DrainW'(DRAIN_CYCLES - 1);

    localparam logic [NB_FWD-1:0] FwdNone = '0;
    localparam logic [NB_FWD-1:0] FwdWb   = NB_FWD'(1);
    localparam logic [NB_FWD-1:0] FwdMem  = NB_FWD'(2);

    typedef enum logic [2:0] {StWait, StRun, StStep, StDrain, StHalted} state_e;

    state_e            state_q, state_d;
    logic [DrainW-1:0] drain_cnt_q, drain_cnt_d;
    logic              advance;
    logic              stall;
    logic              halt_go;
    logic              flush;

    // EX/MEM wins over MEM/WB; register 0 is hardwired and never forwarded.
    function automatic logic [NB_FWD-1:0] fwd_sel(
        input logic [NB_ADDRESS_REGISTROS-1:0] src,
        input logic [NB_ADDRESS_REGISTROS-1:0] rd_mem,
        input logic                            wr_mem,
        input logic [NB_ADDRESS_REGISTROS-1:0] rd_wb,
        input logic                            wr_wb
    );
        if (wr_mem && (rd_mem != '0) && (rd_mem == src)) begin
            return FwdMem;
        end else if (wr_wb && (rd_wb != '0) && (rd_wb == src)) begin
            return FwdWb;
        end
        return FwdNone;
    endfunction

    assign o_fwd_a = fwd_sel(i_rs_ex, i_rd_mem, i_reg_write_mem, i_rd_wb, i_reg_write_wb);
    assign o_fwd_b = fwd_sel(i_rt_ex, i_rd_mem, i_reg_write_mem, i_rd_wb, i_reg_write_wb);

    assign advance = (state_q == StRun) || (state_q == StStep);
    assign stall   = i_mem_read_ex && (i_rt_ex != '0) &&
                     ((i_rt_ex == i_rs_id) || (i_rt_ex == i_rt_id));
    // A stalled HALT stays in ID and retries; a taken branch kills it.
    assign halt_go = advance && i_halt_id && !i_branch_taken && !stall;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= StWait;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        unique case (state_q)
            StWait: begin
                if (!i_debug_mode) begin
                    state_d = StRun;
                end else if (i_step) begin
                    state_d = StStep;
                end
            end
            StRun: begin
                if (halt_go) begin
                    state_d     = StDrain;
                    drain_cnt_d = '0;
                end else if (i_debug_mode) begin
                    state_d = StWait;
                end
            end
            StStep: begin
                if (halt_go) begin
                    state_d     = StDrain;
                    drain_cnt_d = '0;
                end else begin
                    state_d = StWait;
                end
            end
            StDrain: begin
                if (drain_cnt_q == DrainLast) begin
                    state_d     = StHalted;
                    drain_cnt_d = '0;
                end else begin
                    drain_cnt_d = drain_cnt_q + DrainW'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        o_pc_en        = 1'b0;
        o_if_id_en     = 1'b0;
        o_id_ex_bubble = 1'b0;
        flush          = 1'b0;
        unique case (state_q)
            StRun, StStep: begin
                if (i_branch_taken) begin
                    // Branch overrides the stall: refetch from the target.
                    o_pc_en    = 1'b1;
                    o_if_id_en = 1'b1;
                    flush      = 1'b1;
                end else if (stall) begin
                    o_id_ex_bubble = 1'b1;
                end else begin
                    o_pc_en    = 1'b1;
                    o_if_id_en = 1'b1;
                end
            end
            StDrain: begin
                o_id_ex_bubble = 1'b1;
                if (i_branch_taken) begin
                    o_pc_en = 1'b1;
                    flush   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign o_if_id_flush  = flush;
    assign o_id_ex_flush  = flush;
    assign o_ex_mem_flush = flush;
    assign o_halted       = (state_q == StHalted);

`ifdef PIPE_CYCLE_COUNT_EN
    logic [NB_CYCLES-1:0] cycle_count_q;
    logic                 count_active;

    assign count_active = advance || (state_q == StDrain);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cycle_count_q <= '0;
        end else if (count_active) begin
            cycle_count_q <= cycle_count_q + NB_CYCLES'(1);
        end
    end

    assign o_cycle_count = cycle_count_q;
`else
    assign o_cycle_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

    localparam int DC = 3;
    localparam int MWait = 0, MRun = 1, MStep = 2, MDrain = 3, MHalted = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, debug_mode, step, halt_id, mem_read_ex, reg_write_mem, reg_write_wb;
    logic       branch_taken;
    logic [4:0] rs_id, rt_id, rs_ex, rt_ex, rd_mem, rd_wb;
    logic       pc_en, if_id_en, id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush, halted;
    logic [1:0] fwd_a, fwd_b;
    logic [31:0] cycle_count;

    pipeline_ctrl dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_debug_mode    (debug_mode),
        .i_step          (step),
        .i_halt_id       (halt_id),
        .i_rs_id         (rs_id),
        .i_rt_id         (rt_id),
        .i_rs_ex         (rs_ex),
        .i_rt_ex         (rt_ex),
        .i_mem_read_ex   (mem_read_ex),
        .i_rd_mem        (rd_mem),
        .i_reg_write_mem (reg_write_mem),
        .i_rd_wb         (rd_wb),
        .i_reg_write_wb  (reg_write_wb),
        .i_branch_taken  (branch_taken),
        .o_pc_en         (pc_en),
        .o_if_id_en      (if_id_en),
        .o_id_ex_bubble  (id_ex_bubble),
        .o_if_id_flush   (if_id_flush),
        .o_id_ex_flush   (id_ex_flush),
        .o_ex_mem_flush  (ex_mem_flush),
        .o_fwd_a         (fwd_a),
        .o_fwd_b         (fwd_b),
        .o_halted        (halted),
        .o_cycle_count   (cycle_count)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural reference: mode, remaining drain cycles, active-cycle total.
    int          m_st;
    int          m_drain_left;
    logic [31:0] m_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input logic [31:0] v);
`ifdef PIPE_CYCLE_COUNT_EN
        return v;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic m_stall();
        return mem_read_ex && rt_ex != 5'd0 && (rt_ex == rs_id || rt_ex == rt_id);
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] src);
        if (reg_write_mem && rd_mem != 5'd0 && rd_mem == src) return 2'b10;
        if (reg_write_wb && rd_wb != 5'd0 && rd_wb == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_st         = MWait;
        m_drain_left = 0;
        m_count      = 32'd0;
    endtask

    task automatic check_all(input string tag);
        logic e_pc, e_ifid, e_bub, e_fl;
        e_pc = 1'b0; e_ifid = 1'b0; e_bub = 1'b0; e_fl = 1'b0;
        if (m_st == MRun || m_st == MStep) begin
            if (branch_taken) begin
                e_pc = 1'b1; e_ifid = 1'b1; e_fl = 1'b1;
            end else if (m_stall()) begin
                e_bub = 1'b1;
            end else begin
                e_pc = 1'b1; e_ifid = 1'b1;
            end
        end else if (m_st == MDrain) begin
            e_bub = 1'b1;
            if (branch_taken) begin
                e_pc = 1'b1; e_fl = 1'b1;
            end
        end
        chk({tag, ".pc_en"}, pc_en, e_pc);
        chk({tag, ".if_id_en"}, if_id_en, e_ifid);
        chk({tag, ".bubble"}, id_ex_bubble, e_bub);
        chk({tag, ".flushes"}, {if_id_flush, id_ex_flush, ex_mem_flush}, {3{e_fl}});
        chk({tag, ".fwd_a"}, fwd_a, m_fwd(rs_ex));
        chk({tag, ".fwd_b"}, fwd_b, m_fwd(rt_ex));
        chk({tag, ".halted"}, halted, m_st == MHalted);
        chk({tag, ".count"}, cycle_count, exp_cnt(m_count));
    endtask

    task automatic tick();
        int          nst  = m_st;
        int          ndl  = m_drain_left;
        logic [31:0] ncnt = m_count;
        logic        st   = m_stall();
        if (!rst) begin
            case (m_st)
                MWait: begin
                    if (!debug_mode) nst = MRun;
                    else if (step) nst = MStep;
                end
                MRun, MStep: begin
                    if (halt_id && !branch_taken && !st) begin
                        nst = MDrain;
                        ndl = DC;
                    end else if (m_st == MStep || debug_mode) begin
                        nst = MWait;
                    end
                end
                MDrain: begin
                    ndl = m_drain_left - 1;
                    if (ndl == 0) nst = MHalted;
                end
                default: ;
            endcase
            if (m_st == MRun || m_st == MStep || m_st == MDrain) ncnt = m_count + 32'd1;
        end
        @(posedge clk);
        if (!rst) begin
            m_st         = nst;
            m_drain_left = ndl;
            m_count      = ncnt;
        end
        #1;
    endtask

    task automatic clear_hazards();
        halt_id = 0; mem_read_ex = 0; reg_write_mem = 0; reg_write_wb = 0; branch_taken = 0;
        rs_id = 0; rt_id = 0; rs_ex = 0; rt_ex = 0; rd_mem = 0; rd_wb = 0; step = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
        #1;
    endtask

    typedef struct {
        logic       mr;
        logic [4:0] rtx, rsi, rti;
        logic       br;
        logic [4:0] rdm;
        logic       wm;
        logic [4:0] rdw;
        logic       ww;
        logic [4:0] rsx;
        logic       e_pc, e_ifid, e_bub, e_fl;
        logic [1:0] e_fa, e_fb;
    } vec_t;

    vec_t vecs[10];
    int   adv;
    int   halted_run;

    initial begin
        vecs[0] = '{1, 8, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00}; // load-use via rs
        vecs[1] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00}; // rt_ex = 0
        vecs[2] = '{1, 9, 3, 9, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00}; // load-use via rt
        vecs[3] = '{0, 9, 9, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00}; // not a load
        vecs[4] = '{1, 8, 8, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 2'b00, 2'b00}; // branch beats stall
        vecs[5] = '{0, 7, 0, 0, 0, 5, 1, 5, 1, 5, 1, 1, 0, 0, 2'b10, 2'b00}; // EX/MEM priority
        vecs[6] = '{0, 7, 0, 0, 0, 5, 0, 5, 1, 5, 1, 1, 0, 0, 2'b01, 2'b00}; // MEM/WB
        vecs[7] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 1, 0, 0, 2'b00, 2'b00}; // r0 never fwd
        vecs[8] = '{0, 6, 0, 0, 0, 6, 1, 6, 1, 2, 1, 1, 0, 0, 2'b00, 2'b10}; // B from EX/MEM
        vecs[9] = '{0, 6, 0, 0, 0, 4, 1, 6, 1, 4, 1, 1, 0, 0, 2'b10, 2'b01}; // split sources

        rst = 1'b1;
        debug_mode = 1'b0;
        clear_hazards();
        model_reset();
        branch_taken = 1'b1;
        #3;
        chk("reset.pc_en", pc_en, 1'b0);
        chk("reset.flushes", {if_id_flush, id_ex_flush, ex_mem_flush}, 3'b000);
        chk("reset.halted", halted, 1'b0);
        chk("reset.count", cycle_count, 32'd0);
        branch_taken = 1'b0;

        // Free run out of reset: one WAIT cycle, then RUN with counter 1, 2, 3.
        tick();
        rst = 1'b0;
        #1;
        chk("wait.pc_en", pc_en, 1'b0);
        check_all("wait");
        tick();
        chk("run0.pc_en", pc_en, 1'b1);
        chk("run0.count", cycle_count, exp_cnt(32'd0));
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("run%0d.count", i), cycle_count, exp_cnt(32'(i)));
            check_all("run");
        end

        // Table vectors, applied in RUN.
        for (int i = 0; i < 10; i++) begin
            mem_read_ex = vecs[i].mr;  rt_ex = vecs[i].rtx; rs_id = vecs[i].rsi;
            rt_id = vecs[i].rti;       branch_taken = vecs[i].br;
            rd_mem = vecs[i].rdm;      reg_write_mem = vecs[i].wm;
            rd_wb = vecs[i].rdw;       reg_write_wb = vecs[i].ww; rs_ex = vecs[i].rsx;
            #1;
            chk($sformatf("vec%0d.pc_en", i), pc_en, vecs[i].e_pc);
            chk($sformatf("vec%0d.if_id_en", i), if_id_en, vecs[i].e_ifid);
            chk($sformatf("vec%0d.bubble", i), id_ex_bubble, vecs[i].e_bub);
            chk($sformatf("vec%0d.flushes", i), {if_id_flush, id_ex_flush, ex_mem_flush},
                {3{vecs[i].e_fl}});
            chk($sformatf("vec%0d.fwd_a", i), fwd_a, vecs[i].e_fa);
            chk($sformatf("vec%0d.fwd_b", i), fwd_b, vecs[i].e_fb);
            tick();
        end
        clear_hazards();

        // Step mode: two pulses five cycles apart give exactly two advances.
        debug_mode = 1'b1;
        tick();
        chk("stepwait.pc_en", pc_en, 1'b0);
        adv = 0;
        for (int i = 0; i < 12; i++) begin
            step = (i == 1 || i == 6);
            #1;
            check_all($sformatf("step%0d", i));
            if (pc_en === 1'b1) adv++;
            tick();
        end
        step = 1'b0;
        chk("step.advances", adv, 2);

        // HALT in RUN: three drain cycles, then sticky halt with frozen counter.
        debug_mode = 1'b0;
        tick();
        halt_id = 1'b1;
        #1;
        check_all("halt.run");
        tick();
        halt_id = 1'b0;
        for (int i = 0; i < DC; i++) begin
            #1;
            chk($sformatf("drain%0d.pc_en", i), pc_en, 1'b0);
            chk($sformatf("drain%0d.bubble", i), id_ex_bubble, 1'b1);
            chk($sformatf("drain%0d.halted", i), halted, 1'b0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("halted%0d.halted", i), halted, 1'b1);
            chk($sformatf("halted%0d.pc_en", i), pc_en, 1'b0);
            check_all("halted");
            tick();
        end

        // Stalled HALT retries; HALT under a taken branch is killed.
        do_reset();
        tick();
        halt_id = 1'b1; mem_read_ex = 1'b1; rt_ex = 5'd4; rs_id = 5'd4;
        #1;
        check_all("halt.stall");
        tick();
        check_all("halt.stall2");
        mem_read_ex = 1'b0; branch_taken = 1'b1;
        #1;
        check_all("halt.branch");
        tick();
        clear_hazards();
        #1;
        check_all("halt.killed");

        // Reset in the middle of DRAIN.
        halt_id = 1'b1;
        tick();
        halt_id = 1'b0;
        tick();
        rst = 1'b1;
        model_reset();
        #1;
        chk("rstdrain.halted", halted, 1'b0);
        chk("rstdrain.count", cycle_count, 32'd0);
        chk("rstdrain.pc_en", pc_en, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk("rstdrain.wait", pc_en, 1'b0);
        tick();

        // Randomized stimulus against the reference model.
        halted_run = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) debug_mode = ~debug_mode;
            step          = ($urandom_range(0, 3) == 0);
            halt_id       = ($urandom_range(0, 15) == 0);
            mem_read_ex   = ($urandom_range(0, 2) == 0);
            branch_taken  = ($urandom_range(0, 7) == 0);
            reg_write_mem = $urandom_range(0, 1) == 1;
            reg_write_wb  = $urandom_range(0, 1) == 1;
            rs_id = 5'($urandom_range(0, 3)); rt_id = 5'($urandom_range(0, 3));
            rs_ex = 5'($urandom_range(0, 3)); rt_ex = 5'($urandom_range(0, 3));
            rd_mem = 5'($urandom_range(0, 3)); rd_wb = 5'($urandom_range(0, 3));
            halted_run = (m_st == MHalted) ? halted_run + 1 : 0;
            if ($urandom_range(0, 59) == 0 || halted_run > 3) begin
                rst = 1'b1;
                model_reset();
            end else begin
                rst = 1'b0;
            end
            #1;
            check_all("rand");
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
